btn_conditioner: RTL
====================

Name: btn_conditioner

Overview:
Parametrised multi-channel push-button conditioner, successor to the single-button history debouncer. Per channel: 2-flop input synchroniser, stable-count debounce gated by a sample-enable tick, debounced level, one-cycle press/release pulses, and an optional hold-to-repeat pulse train. Sits between raw board buttons/switches and the control FSMs that consume single-cycle strobes.

Parameters:
N_CH, 4, number of independent button channels
STABLE_CNT, 20, consecutive disagreeing sample ticks needed to accept a new level (>=1)
REPEAT_DELAY, 50, sample ticks from accepted press to first repeat pulse (>=1)
REPEAT_PERIOD, 10, sample ticks between subsequent repeat pulses (>=1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
sample_en  in  1  debounce/repeat time-base tick; counters advance only when high
rpt_en  in  1  global auto-repeat enable
btn_in  in  N_CH  raw asynchronous button inputs
btn_lvl  out  N_CH  debounced level, registered
btn_press  out  N_CH  one-clk pulse on accepted 0->1
btn_release  out  N_CH  one-clk pulse on accepted 1->0
btn_repeat  out  N_CH  one-clk pulse per auto-repeat event

Behaviour:
- Reset: clk, rst as decided (synchronous, active-high). All sync flops, counters, FSMs and all outputs = 0. Reset mid-operation aborts any count/repeat; no pulse in the reset cycle or the cycle after.
- Channels fully independent; identical logic instantiated per bit.
- Sync: s1 <= btn_in[i], s2 <= s1 every clk (not gated by sample_en).
- Debounce counter, width clog2(STABLE_CNT+1), on sample_en=1 only:
  - s2 == btn_lvl: cnt <= 0.
  - s2 != btn_lvl and cnt == STABLE_CNT-1: btn_lvl <= s2, cnt <= 0, pulse btn_press (if s2=1) or btn_release (if s2=0) for exactly the following clk.
  - otherwise cnt <= cnt+1.
  - sample_en=0: cnt holds.
- Latency (sample_en tied 1): input step before edge k -> btn_lvl and pulse change at edge k+1+STABLE_CNT. Any glitch shorter than STABLE_CNT ticks after sync is rejected; one agreeing tick clears cnt.
- Repeat FSM per channel, states IDLE, WAIT, RPT; counter rcnt, width clog2(max(DELAY,PERIOD)+1):
  - IDLE -> WAIT, rcnt<=0: on the edge btn_lvl rises with rpt_en=1, or any edge with btn_lvl=1, rpt_en=1 in IDLE.
  - WAIT, tick: rcnt==REPEAT_DELAY-1 -> btn_repeat pulse, RPT, rcnt<=0; else rcnt+1.
  - RPT, tick: rcnt==REPEAT_PERIOD-1 -> btn_repeat pulse, rcnt<=0; else rcnt+1.
  - Any state -> IDLE, rcnt<=0 when rpt_en=0 or on the edge btn_lvl falls; release takes priority, no repeat on that edge.
- btn_press and btn_repeat never assert in the same cycle for a channel (DELAY>=1).
- Pulses last exactly one clk regardless of sample_en.

Test Plan:
(N_CH=2, STABLE_CNT=4, REPEAT_DELAY=3, REPEAT_PERIOD=2, sample_en=1 unless stated)
1. Clean press: btn_in[0] 0->1 before edge 1 -> btn_lvl[0]=1 from edge 6, btn_press[0] high one clk after edge 6; channel 1 outputs stay 0.
2. Bounce: btn_in[0] toggles every clk for 10 clks, settles at 1 before edge k -> no pulses during bounce; btn_lvl[0] rises at edge k+5 with single btn_press.
3. Repeat: hold btn_in[0], rpt_en=1 -> press at edge 6, btn_repeat[0] at edges 9, 11, 13...; release -> btn_release once, no further repeats; rpt_en=0 run -> zero repeats.
4. Tick gating: sample_en high every 4th clk -> btn_lvl rises on 4th tick with s2=1; cnt frozen between ticks; glitch of 3 ticks rejected.
5. Reset mid-hold: rst high 1 clk during repeat train, btn_in stays 1 -> all outputs 0; with rst sampled at edge r, btn_press again at edge r+6.
6. Release glitch: btn_in[0] low 3 clks while held -> no release, repeat train at period 2 continues unbroken.

Source files
------------

// File: rtl/btn_conditioner.sv
// ---------------------------------------------------------------------------
// btn_conditioner
//   Multi-channel push-button conditioner. Each channel synchronises a raw
//   button input, debounces it using a stable-count filter that advances on
//   sample_en ticks, and then presents the debounced level. It also generates
//   one-clock press and release strobes and an optional hold-to-repeat
//   strobe train.
//
// Parameters
//   N_CH          number of independent channels
//   STABLE_CNT    consecutive disagreeing ticks needed to accept a new level
//   REPEAT_DELAY  ticks from accepted press to the first repeat strobe
//   REPEAT_PERIOD ticks between subsequent repeat strobes
//
// Ports
//   clk          system clock
//   rst          synchronous, active-high reset
//   sample_en    time-base tick; debounce and repeat counters advance on it
//   rpt_en       global auto-repeat enable
//   btn_in       raw asynchronous button inputs
//   btn_lvl      debounced level (registered)
//   btn_press    one-clk strobe on an accepted 0->1 change
//   btn_release  one-clk strobe on an accepted 1->0 change
//   btn_repeat   one-clk strobe per auto-repeat event
// ---------------------------------------------------------------------------
module btn_conditioner #(
    parameter int N_CH          = 4,
    parameter int STABLE_CNT    = 20,
    parameter int REPEAT_DELAY  = 50,
    parameter int REPEAT_PERIOD = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            sample_en,
    input  logic            rpt_en,
    input  logic [N_CH-1:0] btn_in,
    output logic [N_CH-1:0] btn_lvl,
    output logic [N_CH-1:0] btn_press,
    output logic [N_CH-1:0] btn_release,
    output logic [N_CH-1:0] btn_repeat
);

    localparam int CNT_W   = $clog2(STABLE_CNT + 1);
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RCNT_W  = $clog2(RPT_MAX + 1);

    localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'(STABLE_CNT - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);
    localparam logic [RCNT_W-1:0] DELAY_LAST  = RCNT_W'(REPEAT_DELAY - 1);
    localparam logic [RCNT_W-1:0] PERIOD_LAST = RCNT_W'(REPEAT_PERIOD - 1);
    localparam logic [RCNT_W-1:0] RCNT_ONE    = RCNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RPT
    } rpt_state_e;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic              s1_q, s2_q;
        logic              lvl_q, lvl_d;
        logic [CNT_W-1:0]  cnt_q, cnt_d;
        logic              press_q, press_d;
        logic              release_q, release_d;
        logic              rise, fall;
        rpt_state_e        state_q, state_d;
        logic [RCNT_W-1:0] rcnt_q, rcnt_d;
        logic              repeat_q, repeat_d;

        // Debounce: a new level is accepted after STABLE_CNT consecutive ticks
        // that disagree with the current level. Any agreeing tick restarts
        // the count.
        always_comb begin : debounce_next
            // NOTE: every combinationally assigned signal gets a default
            // first, so no path leaves it unassigned and no latch is inferred.
            lvl_d     = lvl_q;
            cnt_d     = cnt_q;
            rise      = 1'b0;
            fall      = 1'b0;
            if (sample_en) begin
                if (s2_q == lvl_q) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    lvl_d = s2_q;
                    cnt_d = '0;
                    rise  = s2_q;
                    fall  = ~s2_q;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            // The strobes are registered, so they appear during the clock
            // that follows the accepting edge, together with the new level.
            press_d   = rise;
            release_d = fall;
        end

        // Repeat FSM. A release or a dropped rpt_en always wins, so no repeat
        // strobe can coincide with the edge on which the level falls.
        always_comb begin : repeat_next
            state_d  = state_q;
            rcnt_d   = rcnt_q;
            repeat_d = 1'b0;
            if (!rpt_en || fall) begin
                state_d = ST_IDLE;
                rcnt_d  = '0;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        // Arms on the accepting edge itself, or later if rpt_en
                        // is raised while the button is already held.
                        if (rise || lvl_q) begin
                            state_d = ST_WAIT;
                            rcnt_d  = '0;
                        end
                    end
                    ST_WAIT: begin
                        if (sample_en) begin
                            if (rcnt_q == DELAY_LAST) begin
                                repeat_d = 1'b1;
                                state_d  = ST_RPT;
                                rcnt_d   = '0;
                            end else begin
                                rcnt_d = rcnt_q + RCNT_ONE;
                            end
                        end
                    end
                    ST_RPT: begin
                        if (sample_en) begin
                            if (rcnt_q == PERIOD_LAST) begin
                                repeat_d = 1'b1;
                                rcnt_d   = '0;
                            end else begin
                                rcnt_d = rcnt_q + RCNT_ONE;
                            end
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                        rcnt_d  = '0;
                    end
                endcase
            end
        end

        // NOTE: the reset is synchronous to match the rest of the codebase.
        // It clears the synchroniser too, so the input needs two clocks to
        // propagate after reset, and no strobe can fire in the cycle after reset.
        always_ff @(posedge clk) begin
            if (rst) begin
                s1_q      <= 1'b0;
                s2_q      <= 1'b0;
                lvl_q     <= 1'b0;
                cnt_q     <= '0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                state_q   <= ST_IDLE;
                rcnt_q    <= '0;
                repeat_q  <= 1'b0;
            end else begin
                // NOTE: non-blocking assignments ensure that every flop
                // samples pre-edge values. This is what makes s1->s2 a
                // genuine two-stage synchroniser.
                s1_q      <= btn_in[i];
                s2_q      <= s1_q;
                lvl_q     <= lvl_d;
                cnt_q     <= cnt_d;
                press_q   <= press_d;
                release_q <= release_d;
                state_q   <= state_d;
                rcnt_q    <= rcnt_d;
                repeat_q  <= repeat_d;
            end
        end

        assign btn_lvl[i]     = lvl_q;
        assign btn_press[i]   = press_q;
        assign btn_release[i] = release_q;
        assign btn_repeat[i]  = repeat_q;
    end

endmodule
